// File: rtl/rptr_handler.sv
// -----------------------------------------------------------------------------
// rptr_handler
//   Read-side pointer and output controller of an asynchronous FIFO. Lives
//   entirely in the read clock domain. It keeps the binary/Gray read pointers,
//   derives registered empty / almost-empty / word-count status from the
//   synchronized Gray write pointer, drives the synchronous-read memory port,
//   and presents data through a 2-entry first-word-fall-through buffer on a
//   valid/ready handshake.
//
// Ports
//   rclk        : read clock
//   rrst        : asynchronous active-high reset
//   g_wptr_sync : Gray write pointer already synchronized into rclk
//   b_rptr      : registered binary read pointer (low bits = memory address)
//   g_rptr      : registered Gray read pointer (to write-domain synchronizer)
//   mem_rd_en   : memory read strobe
//   mem_rdata   : memory read data, valid the cycle after mem_rd_en is sampled
//   empty       : registered, no unread words remain in memory
//   aempty      : registered, rcount <= AEMPTY_THRESH
//   rcount      : registered count of words in memory (excludes output buffer)
//   dout        : head word of the output buffer
//   dout_valid  : dout holds a valid word
//   dout_ready  : consumer accepts dout (pop = dout_valid & dout_ready)
// -----------------------------------------------------------------------------
module rptr_handler #(
  parameter int PTR_WIDTH     = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [PTR_WIDTH:0]    g_wptr_sync,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  empty,
  output logic                  aempty,
  output logic [PTR_WIDTH:0]    rcount,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam logic [PTR_WIDTH:0] AE_THRESH = (PTR_WIDTH+1)'(AEMPTY_THRESH);

  // Gray-to-binary: bit i is the XOR of Gray bits PTR_WIDTH..i.
  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Registered state
  logic [PTR_WIDTH:0]    b_rptr_r;
  logic [PTR_WIDTH:0]    g_rptr_r;
  logic                  empty_r;
  logic                  aempty_r;
  logic [PTR_WIDTH:0]    rcount_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic                  head_v_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic                  skid_v_r;
  logic                  inflight_r;

  // Combinational next-state
  logic                  pop_s;
  logic [1:0]            occ_s;
  logic [1:0]            avail_s;
  logic                  rd_en_s;
  logic [PTR_WIDTH:0]    b_rptr_next_s;
  logic [PTR_WIDTH:0]    g_rptr_next_s;
  logic [PTR_WIDTH:0]    b_wsync_s;
  logic [PTR_WIDTH:0]    rcount_next_s;
  logic [DATA_WIDTH-1:0] head_d_s;
  logic                  head_v_d_s;
  logic [DATA_WIDTH-1:0] skid_d_s;
  logic                  skid_v_d_s;

  // Read issue and pointer/status next values. occ counts buffered words plus
  // the word returning from memory; a read is issued only if, after this
  // cycle's pop, fewer than two slots are committed.
  always_comb begin
    pop_s         = head_v_r & dout_ready;
    occ_s         = {1'b0, head_v_r} + {1'b0, skid_v_r} + {1'b0, inflight_r};
    avail_s       = occ_s - {1'b0, pop_s};
    rd_en_s       = ~empty_r & (avail_s < 2'd2);
    b_rptr_next_s = b_rptr_r + {{PTR_WIDTH{1'b0}}, rd_en_s};
    g_rptr_next_s = b_rptr_next_s ^ (b_rptr_next_s >> 1);
    b_wsync_s     = gray2bin(g_wptr_sync);
    rcount_next_s = b_wsync_s - b_rptr_next_s;
  end

  // Output buffer next state. Returning data goes to head when head is free
  // (or being vacated with no skid word behind it), otherwise to skid. On a
  // pop with skid full, skid shifts to head in the same edge.
  always_comb begin
    head_d_s   = head_r;
    head_v_d_s = head_v_r;
    skid_d_s   = skid_r;
    skid_v_d_s = skid_v_r;
    if (pop_s && skid_v_r) begin
      head_d_s   = skid_r;
      head_v_d_s = 1'b1;
      if (inflight_r) begin
        skid_d_s   = mem_rdata;
        skid_v_d_s = 1'b1;
      end else begin
        skid_v_d_s = 1'b0;
      end
    end else if (pop_s) begin
      if (inflight_r) begin
        head_d_s   = mem_rdata;
        head_v_d_s = 1'b1;
      end else begin
        head_v_d_s = 1'b0;
      end
    end else if (inflight_r) begin
      if (!head_v_r) begin
        head_d_s   = mem_rdata;
        head_v_d_s = 1'b1;
      end else begin
        skid_d_s   = mem_rdata;
        skid_v_d_s = 1'b1;
      end
    end else begin
      head_v_d_s = head_v_r;
    end
  end

  // State registers. Clearing inflight on reset discards any word still
  // returning from a pre-reset read.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      b_rptr_r   <= '0;
      g_rptr_r   <= '0;
      empty_r    <= 1'b1;
      aempty_r   <= 1'b1;
      rcount_r   <= '0;
      head_r     <= '0;
      head_v_r   <= 1'b0;
      skid_r     <= '0;
      skid_v_r   <= 1'b0;
      inflight_r <= 1'b0;
    end else begin
      b_rptr_r   <= b_rptr_next_s;
      g_rptr_r   <= g_rptr_next_s;
      empty_r    <= (g_rptr_next_s == g_wptr_sync);
      aempty_r   <= (rcount_next_s <= AE_THRESH);
      rcount_r   <= rcount_next_s;
      head_r     <= head_d_s;
      head_v_r   <= head_v_d_s;
      skid_r     <= skid_d_s;
      skid_v_r   <= skid_v_d_s;
      inflight_r <= rd_en_s;
    end
  end

  assign b_rptr     = b_rptr_r;
  assign g_rptr     = g_rptr_r;
  assign mem_rd_en  = rd_en_s;
  assign empty      = empty_r;
  assign aempty     = aempty_r;
  assign rcount     = rcount_r;
  assign dout       = head_r;
  assign dout_valid = head_v_r;

endmodule

// File: doc/rptr_handler.md
# rptr_handler

Read-side pointer and output controller for the asynchronous FIFO. It lives entirely in the read clock domain. It keeps the binary and Gray read pointers, derives the registered `empty`, `aempty` and `rcount` status from the synchronized Gray write pointer, and drives the synchronous-read memory port. A 2-entry first-word-fall-through output buffer presents data on a valid/ready handshake at one word per cycle.

## Interface
- `PTR_WIDTH`, default 8: address width; memory depth is 2^PTR_WIDTH and pointers are PTR_WIDTH+1 bits.
- `DATA_WIDTH`, default 8: word width.
- `AEMPTY_THRESH`, default 4: `aempty` asserts when `rcount` <= this value.
- `rclk`, in, 1: read clock. Single clock domain.
- `rrst`, in, 1: reset, asynchronous and active-high.
- `g_wptr_sync`, in, PTR_WIDTH+1: Gray write pointer, already synchronized into `rclk`.
- `b_rptr`, out, PTR_WIDTH+1: binary read pointer, registered. `b_rptr[PTR_WIDTH-1:0]` is the memory read address.
- `g_rptr`, out, PTR_WIDTH+1: Gray read pointer, registered, sent to the write-domain synchronizer.
- `mem_rd_en`, out, 1: memory read strobe, combinational from registered state and `dout_ready`.
- `mem_rdata`, in, DATA_WIDTH: memory data, valid the cycle after the `rclk` edge that sampled `mem_rd_en`.
- `empty`, out, 1: registered; no unread words remain in memory.
- `aempty`, out, 1: registered almost-empty flag.
- `rcount`, out, PTR_WIDTH+1: registered count of words in memory, excluding the output buffer.
- `dout`, out, DATA_WIDTH: head word of the output buffer.
- `dout_valid`, out, 1: `dout` holds a valid word.
- `dout_ready`, in, 1: consumer accepts `dout`; a pop occurs when `dout_valid & dout_ready`.

## Operation
- Pointers:
  - b_rptr_next = b_rptr + mem_rd_en, modulo 2^(PTR_WIDTH+1).
  - g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1).
  - Both pointers register every edge.
- Empty: empty <= (g_rptr_next == g_wptr_sync). Comparison is on full PTR_WIDTH+1 bits, MSB included.
- Count:
  - b_wsync = Gray-to-binary of g_wptr_sync, where bit i = XOR of bits PTR_WIDTH..i.
  - rcount <= b_wsync - b_rptr_next, modulo 2^(PTR_WIDTH+1). Range is 0..2^PTR_WIDTH.
  - aempty <= (rcount_next <= AEMPTY_THRESH).
- Output buffer:
  - Two entries: head (`dout`) and skid.
  - `inflight` is 1 in the cycle after a read issue.
  - occ = buffered words (0..2) + inflight.
- Read issue: mem_rd_en = !empty && (occ - pop) < 2. The buffer never overflows and never reads past empty.
- Data capture, when `inflight` is 1:
  - `mem_rdata` goes to head if head is empty, or if head is popped this cycle and skid is empty.
  - Otherwise it goes to skid.
  - On a pop with skid full, skid moves to head in the same edge as any capture into skid.
- Simultaneous pop and capture keeps occupancy unchanged. Data order is strictly preserved.
- Reset (asynchronous, any time, including mid-burst):
  - b_rptr = 0, g_rptr = 0.
  - empty = 1, aempty = 1, rcount = 0.
  - dout_valid = 0, dout = 0.
  - inflight = 0, buffer cleared.
  - Data returned after reset release for a pre-reset read is discarded.
- Wrap-around: pointers roll from 2^(PTR_WIDTH+1)-1 to 0. The Gray MSB toggles once per 2^PTR_WIDTH reads. `empty` and `rcount` stay correct across the wrap.

## Timing
- Fill latency:
  - Edge 0: `g_wptr_sync` first goes nonzero.
  - Edge 1: `empty` falls.
  - Cycle after edge 1: `mem_rd_en` is high.
  - Edge 2: pointers advance.
  - Edge 3: `dout_valid` rises.
  - Total: 3 edges from write-pointer visibility to first output.
- Throughput: 1 word/cycle sustained with `dout_ready` held high and `empty` low.
- `dout` and `dout_valid` change only on `rclk` edges. `dout` is stable while `dout_valid & !dout_ready`.
- The last read sets `empty` on the same edge that advances `b_rptr`. No extra read is issued.
- `aempty` and `rcount` update on the same edge as `empty`.

## Test plan
- Reset: assert `rrst` mid-cycle with no clock.
  - All outputs take their reset values immediately.
  - `mem_rd_en` = 0 with `empty` = 1.
- Single word: after reset, g_wptr_sync = 1.
  - `empty` falls at edge 1; `mem_rd_en` pulses once.
  - `dout_valid` at edge 3 with data from address 0.
  - `empty` = 1 again, b_rptr = 1, g_rptr = 1.
- Streaming: memory holds 0..9, g_wptr_sync = Gray(10), `dout_ready` = 1.
  - 10 consecutive valid words 0..9, one per cycle.
  - End state: b_rptr = 10, rcount = 0, aempty = 1.
- Backpressure: same preload with `dout_ready` = 0.
  - Exactly 2 reads issue, then `mem_rd_en` stays low.
  - Release `dout_ready`: words 0..9 arrive in order, none lost or duplicated.
- Wrap: PTR_WIDTH = 3; stream 20 words with the write pointer kept ahead.
  - b_rptr rolls 15 -> 0.
  - `empty` and `rcount` match a reference model every cycle.
- Mid-burst reset: pulse `rrst` while `inflight` = 1 and skid is full.
  - After release, `dout_valid` = 0 and pointers = 0.
  - The stale `mem_rdata` is not presented.
